// File: rtl/pool_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pool_mem_responder: byte scratchpad with single-beat writes and multi-beat |
// | reads. Optional macro POOL_MEM_RESP_ERR_EN adds mem_err. Rev 1.0           |
// +----------------------------------------------------------------------------+
module pool_mem_responder #(
  parameter int ADDR_WIDTH           = 12,
  parameter int MEM_DATA_BUS         = 128,
  parameter int MAX_BYTES_TO_RD      = 20,
  parameter int LOG2_MAX_BYTES_TO_RD = $clog2(MAX_BYTES_TO_RD),
  parameter int MAX_BYTES_TO_WR      = 5,
  parameter int LOG2_MAX_BYTES_TO_WR = $clog2(MAX_BYTES_TO_WR)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_req,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [LOG2_MAX_BYTES_TO_WR-1:0] wr_n_bytes,
  input  logic [MEM_DATA_BUS-1:0]         wr_data,
  output logic                            wr_gnt,
  input  logic                            rd_req,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  input  logic [LOG2_MAX_BYTES_TO_RD-1:0] rd_n_bytes,
  output logic                            rd_gnt,
  output logic [MEM_DATA_BUS-1:0]         rd_data,
  output logic                            rd_valid,
  output logic                            rd_last,
  input  logic                            rd_ready,
`ifdef POOL_MEM_RESP_ERR_EN
  output logic                            mem_err,
`endif
  output logic                            mem_busy
);

  localparam int BPB    = MEM_DATA_BUS / 8;
  localparam int LEFT_W = LOG2_MAX_BYTES_TO_RD + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_LOAD = 2'd1;
  localparam logic [1:0] RD_BEAT = 2'd2;

  logic [7:0]              mem [0:(1<<ADDR_WIDTH)-1];
  logic [1:0]              state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEFT_W-1:0]       left_q;
  logic [LEFT_W-1:0]       rd_len;
  logic [LEFT_W-1:0]       left_next;
  logic [31:0]             wr_len;
  logic                    wr_oversize;
  logic                    rd_oversize;
  logic                    last_beat;
  logic [MEM_DATA_BUS-1:0] beat;
  logic                    unused_wr_hi;

  assign unused_wr_hi = ^wr_data[MEM_DATA_BUS-1:8*MAX_BYTES_TO_WR];

  // Grants are combinational; gating with rst_n keeps them low during reset.
  assign mem_busy = (state != IDLE);
  assign wr_gnt   = rst_n && (state == IDLE) && wr_req;
  assign rd_gnt   = rst_n && (state == IDLE) && rd_req && !wr_req;

  assign wr_oversize = 32'(wr_n_bytes) > 32'(MAX_BYTES_TO_WR);
  assign rd_oversize = 32'(rd_n_bytes) > 32'(MAX_BYTES_TO_RD);

`ifdef POOL_MEM_RESP_ERR_EN
  assign wr_len  = wr_oversize ? 32'd0 : 32'(wr_n_bytes);
  assign rd_len  = rd_oversize ? '0 : LEFT_W'(rd_n_bytes);
  assign mem_err = (wr_gnt && wr_oversize) || (rd_gnt && rd_oversize);
`else
  assign wr_len  = wr_oversize ? 32'(MAX_BYTES_TO_WR) : 32'(wr_n_bytes);
  assign rd_len  = rd_oversize ? LEFT_W'(MAX_BYTES_TO_RD) : LEFT_W'(rd_n_bytes);
`endif

  // Scratchpad is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_gnt) begin
      for (int j = 0; j < MAX_BYTES_TO_WR; j++) begin
        if (j < wr_len) mem[wr_addr + ADDR_WIDTH'(j)] <= wr_data[8*j +: 8];
      end
    end
  end

  always_comb begin
    beat = '0;
    for (int j = 0; j < BPB; j++) begin
      if (j < 32'(left_q)) beat[8*j +: 8] = mem[addr_q + ADDR_WIDTH'(j)];
    end
  end

  assign last_beat = 32'(left_q) <= 32'(BPB);
  assign left_next = last_beat ? '0 : left_q - LEFT_W'(BPB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      left_q   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_gnt) begin
            addr_q <= rd_addr;
            left_q <= rd_len;
            state  <= RD_LOAD;
          end
        end
        RD_LOAD: begin
          rd_data  <= beat;
          rd_valid <= 1'b1;
          rd_last  <= last_beat;
          addr_q   <= addr_q + ADDR_WIDTH'(BPB);
          left_q   <= left_next;
          state    <= RD_BEAT;
        end
        RD_BEAT: begin
          if (rd_ready) begin
            if (rd_last) begin
              rd_data  <= '0;
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              state    <= IDLE;
            end else begin
              rd_data <= beat;
              rd_last <= last_beat;
              addr_q  <= addr_q + ADDR_WIDTH'(BPB);
              left_q  <= left_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pool_mem_responder.sv
`default_nettype none
// Directed self-checking bench for pool_mem_responder.
module tb_pool_mem_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_req;
  logic [11:0]  wr_addr;
  logic [2:0]   wr_n_bytes;
  logic [127:0] wr_data;
  logic         wr_gnt;
  logic         rd_req;
  logic [11:0]  rd_addr;
  logic [4:0]   rd_n_bytes;
  logic         rd_gnt;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic         rd_last;
  logic         rd_ready;
  logic         mem_busy;
`ifdef POOL_MEM_RESP_ERR_EN
  logic         mem_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] B0_100 = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
  localparam logic [127:0] B1_100 = 128'h000000000000000000000000B3B2B1B0;

  always #5 clk = ~clk;

  pool_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_n_bytes(wr_n_bytes), .wr_data(wr_data),
    .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_n_bytes(rd_n_bytes), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
`ifdef POOL_MEM_RESP_ERR_EN
    .mem_err(mem_err),
`endif
    .mem_busy(mem_busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_err(input string tag, input logic exp_err);
`ifdef POOL_MEM_RESP_ERR_EN
    chk({tag, " mem_err"}, 128'(mem_err), 128'(exp_err));
`else
    if (exp_err) $error("FAIL %s mem_err expected without feature", tag);
`endif
  endtask

  // Enters at posedge+1; leaves at the next posedge+1 after the write commits.
  task automatic do_write(input logic [11:0] a, input logic [2:0] n,
                          input logic [127:0] d, input logic exp_err, input string tag);
    wr_req = 1'b1; wr_addr = a; wr_n_bytes = n; wr_data = d;
    @(negedge clk);
    chk({tag, " wr_gnt"}, 128'(wr_gnt), 128'd1);
    chk_err(tag, exp_err);
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  // Grant cycle, then the RD_LOAD gap cycle; returns at the first valid cycle.
  task automatic start_read(input logic [11:0] a, input logic [4:0] n,
                            input logic exp_err, input string tag);
    rd_req = 1'b1; rd_addr = a; rd_n_bytes = n;
    @(negedge clk);
    chk({tag, " rd_gnt"}, 128'(rd_gnt), 128'd1);
    chk_err(tag, exp_err);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    chk({tag, " load valid"}, 128'(rd_valid), 128'd0);
    chk({tag, " load busy"}, 128'(mem_busy), 128'd1);
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [127:0] d, input logic l, input string tag);
    @(negedge clk);
    chk({tag, " valid"}, 128'(rd_valid), 128'd1);
    chk({tag, " data"}, rd_data, d);
    chk({tag, " last"}, 128'(rd_last), 128'(l));
    @(posedge clk); #1;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    chk({tag, " idle valid"}, 128'(rd_valid), 128'd0);
    chk({tag, " idle busy"}, 128'(mem_busy), 128'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_n_bytes = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; rd_n_bytes = '0; rd_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset flags", 128'({wr_gnt, rd_gnt, rd_valid, rd_last, mem_busy}), 128'd0);
    chk("reset rd_data", rd_data, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then single-beat read; junk above byte 4 must be ignored.
    do_write(12'h010, 3'd5, 128'hFFFFFFFF_FFFFFFFF_FFFFFF55_44332211, 1'b0, "wr010");
    start_read(12'h010, 5'd5, 1'b0, "rd010");
    beat(128'h5544332211, 1'b1, "rd010 b0");
    expect_idle("rd010");

    do_write(12'h100, 3'd5, 128'hA4A3A2A1A0, 1'b0, "wr100");
    do_write(12'h105, 3'd5, 128'hA9A8A7A6A5, 1'b0, "wr105");
    do_write(12'h10A, 3'd5, 128'hAEADACABAA, 1'b0, "wr10A");
    do_write(12'h10F, 3'd5, 128'hB3B2B1B0AF, 1'b0, "wr10F");
    start_read(12'h100, 5'd20, 1'b0, "rd100");
    beat(B0_100, 1'b0, "rd100 b0");
    beat(B1_100, 1'b1, "rd100 b1");
    expect_idle("rd100");

    // Backpressure on beat 0 for three cycles.
    rd_ready = 1'b0;
    start_read(12'h100, 5'd20, 1'b0, "bp");
    beat(B0_100, 1'b0, "bp hold1");
    beat(B0_100, 1'b0, "bp hold2");
    beat(B0_100, 1'b0, "bp hold3");
    rd_ready = 1'b1;
    beat(B0_100, 1'b0, "bp b0");
    beat(B1_100, 1'b1, "bp b1");
    expect_idle("bp");

    // Simultaneous requests: write wins, read follows and sees new data.
    rd_req = 1'b1; rd_addr = 12'h020; rd_n_bytes = 5'd3;
    wr_req = 1'b1; wr_addr = 12'h020; wr_n_bytes = 3'd3; wr_data = 128'hC3C2C1;
    @(negedge clk);
    chk("sim wr_gnt", 128'(wr_gnt), 128'd1);
    chk("sim rd_gnt held", 128'(rd_gnt), 128'd0);
    @(posedge clk); #1;
    wr_req = 1'b0;
    start_read(12'h020, 5'd3, 1'b0, "sim rd");
    beat(128'hC3C2C1, 1'b1, "sim b0");
    expect_idle("sim");

    // Address wrap at the top of the scratchpad.
    do_write(12'hFFE, 3'd4, 128'hD4D3D2D1, 1'b0, "wrap wr");
    start_read(12'hFFE, 5'd4, 1'b0, "wrap rd");
    beat(128'hD4D3D2D1, 1'b1, "wrap b0");
    expect_idle("wrap");
    start_read(12'h000, 5'd1, 1'b0, "wrap rd0");
    beat(128'hD3, 1'b1, "wrap rd0 b0");
    expect_idle("wrap rd0");

    // Zero-length write leaves storage alone; zero-length read gives one zero beat.
    do_write(12'h010, 3'd0, 128'hEEEEEEEEEE, 1'b0, "zwr");
    start_read(12'h010, 5'd5, 1'b0, "zwr chk");
    beat(128'h5544332211, 1'b1, "zwr chk b0");
    expect_idle("zwr chk");
    start_read(12'h010, 5'd0, 1'b0, "zrd");
    beat(128'h0, 1'b1, "zrd b0");
    expect_idle("zrd");

    // Oversize counts.
    do_write(12'h200, 3'd5, 128'h0102030405, 1'b0, "ov pre1");
    do_write(12'h205, 3'd2, 128'hBBAA, 1'b0, "ov pre2");
`ifdef POOL_MEM_RESP_ERR_EN
    do_write(12'h200, 3'd7, 128'h77665544332211, 1'b1, "ov wr");
    start_read(12'h200, 5'd5, 1'b0, "ov chk");
    beat(128'h0102030405, 1'b1, "ov chk b0");
    expect_idle("ov chk");
    start_read(12'h100, 5'd25, 1'b1, "ov rd");
    beat(128'h0, 1'b1, "ov rd b0");
    expect_idle("ov rd");
`else
    do_write(12'h200, 3'd7, 128'h77665544332211, 1'b0, "ov wr");
    start_read(12'h200, 5'd7, 1'b0, "ov chk");
    beat(128'hBBAA5544332211, 1'b1, "ov chk b0");
    expect_idle("ov chk");
    start_read(12'h100, 5'd25, 1'b0, "ov rd");
    beat(B0_100, 1'b0, "ov rd b0");
    beat(B1_100, 1'b1, "ov rd b1");
    expect_idle("ov rd");
`endif

    // Reset in the middle of a two-beat read aborts it immediately.
    rd_ready = 1'b0;
    start_read(12'h100, 5'd20, 1'b0, "rst rd");
    beat(B0_100, 1'b0, "rst rd b0");
    rst_n = 1'b0;
    #1;
    chk("rst abort valid", 128'(rd_valid), 128'd0);
    chk("rst abort busy", 128'(mem_busy), 128'd0);
    chk("rst abort data", rd_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b1;
    start_read(12'h010, 5'd5, 1'b0, "post rst");
    beat(128'h5544332211, 1'b1, "post rst b0");
    expect_idle("post rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
